// File: rtl/mux_scan_ctrl_if.sv
// Control/status bundle between a display sequencer and its requester.
// The sequencer attaches as slave; the requester (host or bench) attaches as master.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               start;
  logic               stop;
  logic               loop;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         last_idx;
  logic               pause;
  logic               jump_req;
  logic [3:0]         jump_idx;
  logic               jump_ack;
  logic [3:0]         sel;
  logic               busy;
  logic               step_tick;
  logic               sweep_done;

  modport master (
    output start, stop, loop, dwell, last_idx, pause, jump_req, jump_idx,
    input  jump_ack, sel, busy, step_tick, sweep_done
  );

  modport slave (
    input  start, stop, loop, dwell, last_idx, pause, jump_req, jump_idx,
    output jump_ack, sel, busy, step_tick, sweep_done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sweeps the 9-entry display mux select 0..last at a programmable dwell,
// with pause, abort and a handshaked jump; parks at 4'b1111 (blank) when idle.
module mux_scan_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_scan_ctrl_if.slave      bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] SEL_BLANK = 4'b1111;
  localparam logic [3:0] LAST_MAX  = 4'd8;

  state_t             state, state_n;
  logic [3:0]         sel_q, sel_n;
  logic [3:0]         last_q, last_n, last_clamped;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               loop_q, loop_n;
  logic               step_q, step_n;
  logic               done_q, done_n;
  logic               ack_q, ack_n;
  logic               armed, armed_n;
  logic               jump_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= SEL_BLANK;
      cnt     <= '0;
      dwell_q <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      cnt     <= cnt_n;
      dwell_q <= dwell_n;
      last_q  <= last_n;
      loop_q  <= loop_n;
      step_q  <= step_n;
      done_q  <= done_n;
      ack_q   <= ack_n;
      armed   <= armed_n;
    end
  end

  // A request held high across its ack must drop for a cycle before it can be taken again.
  always_comb begin
    state_n      = state;
    sel_n        = sel_q;
    cnt_n        = cnt;
    dwell_n      = dwell_q;
    last_n       = last_q;
    loop_n       = loop_q;
    step_n       = 1'b0;
    done_n       = 1'b0;
    last_clamped = (bus.last_idx > LAST_MAX) ? LAST_MAX : bus.last_idx;
    jump_take    = bus.jump_req && !ack_q && armed;
    ack_n        = jump_take;
    armed_n      = !bus.jump_req ? 1'b1 : (jump_take ? 1'b0 : armed);

    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n = SCAN;
          loop_n  = bus.loop;
          dwell_n = bus.dwell;
          last_n  = last_clamped;
          sel_n   = 4'd0;
          cnt_n   = bus.dwell;
          step_n  = 1'b1;
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_n = IDLE;
          sel_n   = SEL_BLANK;
        end else if (jump_take && (bus.jump_idx <= last_q)) begin
          sel_n  = bus.jump_idx;
          cnt_n  = dwell_q;
          step_n = 1'b1;
        end else if (!bus.pause) begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (sel_q < last_q) begin
            sel_n  = sel_q + 4'd1;
            cnt_n  = dwell_q;
            step_n = 1'b1;
          end else if (loop_q) begin
            sel_n  = 4'd0;
            cnt_n  = dwell_q;
            step_n = 1'b1;
            done_n = 1'b1;
          end else begin
            state_n = IDLE;
            sel_n   = SEL_BLANK;
            done_n  = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = SEL_BLANK;
      end
    endcase
  end

  always_comb begin
    bus.busy       = (state == SCAN);
    bus.sel        = sel_q;
    bus.step_tick  = step_q;
    bus.sweep_done = done_q;
    bus.jump_ack   = ack_q;
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus queues expected output events
// (cycle-stamped); a negedge monitor pops and compares each presented event.
module tb_mux_scan_ctrl;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  mux_scan_ctrl_if #(.DWELL_W(DW)) bus ();

  mux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  sel;
    logic        busy;
    logic        step;
    logic        done;
    logic        ack;
  } ev_t;

  ev_t expq[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Any step_tick, sweep_done or jump_ack is an event that must match the queue head.
  always @(negedge clk) begin : monitor
    ev_t a, e;
    if (bus.step_tick || bus.sweep_done || bus.jump_ack) begin
      a.cyc  = cyc;
      a.sel  = bus.sel;
      a.busy = bus.busy;
      a.step = bus.step_tick;
      a.done = bus.sweep_done;
      a.ack  = bus.jump_ack;
      n_checks++;
      if (expq.size() == 0) begin
        $display("FAIL unexpected_event: got cyc=%0d sel=%0h busy=%0b step=%0b done=%0b ack=%0b, expected none",
                 a.cyc, a.sel, a.busy, a.step, a.done, a.ack);
      end else begin
        e = expq.pop_front();
        if (a === e) n_pass++;
        else $display("FAIL event: got cyc=%0d sel=%0h busy=%0b step=%0b done=%0b ack=%0b, expected cyc=%0d sel=%0h busy=%0b step=%0b done=%0b ack=%0b",
                      a.cyc, a.sel, a.busy, a.step, a.done, a.ack, e.cyc, e.sel, e.busy, e.step, e.done, e.ack);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic exp_ev(input int c, input logic [3:0] s, input logic b, input logic st,
                        input logic d, input logic a);
    ev_t e;
    e.cyc = c; e.sel = s; e.busy = b; e.step = st; e.done = d; e.ack = a;
    expq.push_back(e);
  endtask

  task automatic start_sweep(input logic l, input logic [DW-1:0] dw, input logic [3:0] li);
    bus.start = 1'b1; bus.loop = l; bus.dwell = dw; bus.last_idx = li;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t;
    bus.start = 0; bus.stop = 0; bus.loop = 0; bus.dwell = '0; bus.last_idx = '0;
    bus.pause = 0; bus.jump_req = 0; bus.jump_idx = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_sel",  bus.sel, 4'hF);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack",  bus.jump_ack, 0);
    chk("rst_step", bus.step_tick, 0);
    chk("rst_done", bus.sweep_done, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_sel", bus.sel, 4'hF);

    // One-shot, dwell=2, last=3
    t = cyc + 1;
    for (int k = 0; k < 4; k++) exp_ev(t + 3*k, k[3:0], 1, 1, 0, 0);
    exp_ev(t + 12, 4'hF, 0, 0, 1, 0);
    start_sweep(0, 2, 3);
    wait_cyc(t + 11);
    chk("oneshot_last_hold", bus.sel, 3);
    tick();
    chk("oneshot_end_busy", bus.busy, 0);
    tick();

    // Loop with last clamped to 8, dwell=0, then stop
    t = cyc + 1;
    for (int k = 0; k < 19; k++) exp_ev(t + k, 4'(k % 9), 1, 1, (k == 9 || k == 18), 0);
    start_sweep(1, 0, 12);
    wait_cyc(t + 18);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("loop_stop_sel",  bus.sel, 4'hF);
    chk("loop_stop_busy", bus.busy, 0);
    chk("loop_stop_done", bus.sweep_done, 0);
    tick();

    // Pause for 5 cycles during index 2, dwell=4
    t = cyc + 1;
    exp_ev(t, 0, 1, 1, 0, 0);
    exp_ev(t + 5, 1, 1, 1, 0, 0);
    exp_ev(t + 10, 2, 1, 1, 0, 0);
    exp_ev(t + 20, 3, 1, 1, 0, 0);
    exp_ev(t + 25, 4'hF, 0, 0, 1, 0);
    start_sweep(0, 4, 3);
    wait_cyc(t + 10);
    bus.pause = 1'b1;
    wait_cyc(t + 15);
    bus.pause = 1'b0;
    chk("pause_hold_sel", bus.sel, 2);
    wait_cyc(t + 19);
    chk("pause_10th_cycle_sel", bus.sel, 2);
    wait_cyc(t + 25);
    chk("pause_end_busy", bus.busy, 0);
    tick();

    // Jumps: in range, out of range, at expiry, re-accept guard, with stop, in IDLE
    t = cyc + 1;
    exp_ev(t,      0,    1, 1, 0, 0);
    exp_ev(t + 2,  5,    1, 1, 0, 1);
    exp_ev(t + 6,  6,    1, 1, 0, 0);
    exp_ev(t + 7,  6,    1, 0, 0, 1);
    exp_ev(t + 10, 0,    1, 1, 1, 0);
    exp_ev(t + 14, 3,    1, 1, 0, 1);
    exp_ev(t + 18, 4,    1, 1, 0, 0);
    exp_ev(t + 19, 4'hF, 0, 0, 0, 1);
    exp_ev(t + 21, 4'hF, 0, 0, 0, 1);
    start_sweep(1, 3, 6);
    wait_cyc(t + 1);
    bus.jump_req = 1'b1; bus.jump_idx = 5;
    tick();
    bus.jump_req = 1'b0;
    wait_cyc(t + 6);
    bus.jump_req = 1'b1; bus.jump_idx = 7;
    tick();
    bus.jump_req = 1'b0;
    chk("jump_oob_sel", bus.sel, 6);
    wait_cyc(t + 13);
    bus.jump_req = 1'b1; bus.jump_idx = 3;
    wait_cyc(t + 16);
    bus.jump_req = 1'b0;
    wait_cyc(t + 18);
    bus.stop = 1'b1; bus.jump_req = 1'b1; bus.jump_idx = 2;
    tick();
    bus.stop = 1'b0; bus.jump_req = 1'b0;
    chk("stop_jump_busy", bus.busy, 0);
    tick();
    bus.jump_req = 1'b1; bus.jump_idx = 1;
    tick();
    bus.jump_req = 1'b0;
    chk("idle_jump_sel", bus.sel, 4'hF);
    tick();

    // start+stop in IDLE stays idle
    bus.start = 1'b1; bus.stop = 1'b1; bus.dwell = 1; bus.last_idx = 2;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_busy", bus.busy, 0);
    tick();
    chk("start_stop_sel", bus.sel, 4'hF);

    // start during SCAN ignored; restart right after one-shot end with last=0
    t = cyc + 1;
    exp_ev(t,     0,    1, 1, 0, 0);
    exp_ev(t + 2, 1,    1, 1, 0, 0);
    exp_ev(t + 4, 2,    1, 1, 0, 0);
    exp_ev(t + 6, 4'hF, 0, 0, 1, 0);
    exp_ev(t + 7, 0,    1, 1, 0, 0);
    exp_ev(t + 8, 4'hF, 0, 0, 1, 0);
    start_sweep(0, 1, 2);
    tick();
    start_sweep(1, 5, 8);
    wait_cyc(t + 6);
    chk("ignored_start_end_busy", bus.busy, 0);
    start_sweep(0, 0, 0);
    chk("restart_busy", bus.busy, 1);
    tick();
    chk("restart_end_sel", bus.sel, 4'hF);
    tick();

    // Asynchronous reset mid-SCAN at sel=5, with a jump outstanding
    t = cyc + 1;
    for (int k = 0; k < 6; k++) exp_ev(t + k, k[3:0], 1, 1, 0, 0);
    start_sweep(1, 0, 8);
    wait_cyc(t + 5);
    chk("pre_reset_sel", bus.sel, 5);
    bus.jump_req = 1'b1; bus.jump_idx = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel",  bus.sel, 4'hF);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_ack",  bus.jump_ack, 0);
    repeat (2) tick();
    bus.jump_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_sel",  bus.sel, 4'hF);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_ack",  bus.jump_ack, 0);

    repeat (3) tick();
    chk("queue_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer for the terminal's 9-input, 7-bit display/message multiplexer. It owns the 4-bit mux select: it sweeps indices 0..last at a programmable dwell, once or continuously, and supports pause, abort and a handshaked jump to a specific entry. When idle it parks the select at 4'b1111, which drives the mux's default all-zero (blank) pattern.

## Interface
- DWELL_W, 16, width of the dwell count (cycles per entry minus 1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; honoured only in IDLE
- stop  in  1  abort to IDLE; honoured in any state
- loop  in  1  1 = continuous sweep, 0 = one-shot; sampled with start
- dwell  in  DWELL_W  cycles per entry minus 1; sampled with start
- last_idx  in  4  highest index visited; values >8 clamp to 8; sampled with start
- pause  in  1  freezes the dwell counter while high in SCAN
- jump_req  in  1  request to force the select to jump_idx; level, held until jump_ack
- jump_idx  in  4  target index for a jump
- jump_ack  out  1  one-cycle acknowledge of jump_req
- sel  out  4  mux select (0..8 active, 4'b1111 blank)
- busy  out  1  high in SCAN
- step_tick  out  1  one-cycle pulse whenever sel changes to a new active index
- sweep_done  out  1  one-cycle pulse at the end of each complete sweep

## Operation
- States: IDLE, SCAN. Registered copies: loop_q, dwell_q, last_q (clamped), cnt (DWELL_W bits).
- Reset values: state=IDLE, sel=4'b1111, busy=0, jump_ack=0, step_tick=0, sweep_done=0, cnt=0.
- IDLE → SCAN on start=1 with stop=0:
  - capture loop/dwell/last_q
  - sel←0, cnt←dwell, step_tick=1
- Per-cycle priority in SCAN: stop > accepted jump > dwell expiry > normal count. pause only gates the count and expiry.
- Normal count: if pause=0 and cnt≠0, cnt←cnt−1. If pause=1, cnt holds.
- Expiry (pause=0, cnt=0):
  - if sel<last_q: sel←sel+1, cnt←dwell_q, step_tick=1.
  - if sel=last_q and loop_q=1: sel←0, cnt←dwell_q, step_tick=1, sweep_done=1.
  - if sel=last_q and loop_q=0: state←IDLE, sel←4'b1111, sweep_done=1, step_tick=0.
- stop in SCAN: state←IDLE, sel←4'b1111, no sweep_done. stop in IDLE has no effect and suppresses a simultaneous start.
- start while in SCAN is ignored; the captured parameters are not updated.
- Jump handshake: a request is accepted in a cycle where jump_req=1 and jump_ack=0. jump_ack=1 the next cycle, for exactly one cycle. The requester drops jump_req after seeing ack; a req still high in the cycle after ack is not re-accepted until it has been low for at least one cycle.
  - Accepted in SCAN with jump_idx≤last_q: sel←jump_idx, cnt←dwell_q, step_tick=1, no sweep_done. Overrides an expiry in the same cycle.
  - Accepted in IDLE, or with jump_idx>last_q: acknowledged, no other effect.
  - Accepted in the same cycle as stop: acknowledged, stop wins.
- Each active index is visible for dwell_q+1 unpaused cycles. dwell=0 advances every cycle.
- busy = (state==SCAN).

## Timing
- All outputs are registered.
- start sampled at edge t: sel=0, busy=1 and step_tick=1 visible after edge t.
- Index advance: sel changes on the edge where cnt=0 and pause=0 is sampled. step_tick and sweep_done are coincident with the new sel value.
- One-shot end: busy=0, sel=4'b1111 and sweep_done=1 appear together. start may be accepted the very next cycle.
- Jump latency: 1 cycle from accepted req to sel change and jump_ack.
- Reset mid-operation: all outputs return immediately to reset values. An outstanding jump is dropped, with no ack.

## Test plan
- Reset/idle: rst_n low mid-SCAN with sel=5 → sel=4'b1111, busy=0, jump_ack=0 immediately. Outputs stay at reset values until start.
- One-shot: start with dwell=2, last_idx=3, loop=0 → sel 0,1,2,3 each held 3 cycles, 4 step_ticks, then sweep_done=1 with sel=4'b1111 and busy=0 at cycle 12 after start.
- Loop and clamp: start with dwell=0, last_idx=12, loop=1 → sel cycles 0..8 every cycle. sweep_done pulses on each 8→0 wrap. stop then gives sel=4'b1111 with no sweep_done.
- Pause: dwell=4, pause high for 5 cycles during index 2 → index 2 is visible 10 cycles total. No step_tick while paused.
- Jump: in SCAN with last_q=6, jump_idx=5 → ack 1 cycle later, sel=5, dwell restarts. jump_idx=7 → acked, sel unchanged. Jump in the same cycle as expiry → jump target wins.
- Collisions: start+stop in IDLE → remains IDLE. stop+jump in SCAN → IDLE, jump_ack=1. start during SCAN → ignored, parameters unchanged.
